// File: rtl/lives_controller_pkg.sv
// Shared game definitions for the lives controller: FSM state type, default
// life limits and frame periods, and the saturating life increment.
package lives_controller_pkg;

  localparam int DEF_INIT_LIVES   = 3;
  localparam int DEF_MAX_LIVES    = 7;
  localparam int DEF_READY_FRAMES = 60;
  localparam int DEF_DEATH_FRAMES = 90;

  localparam int LIVES_W = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    PLAY,
    DYING,
    GAME_OVER
  } state_e;

  function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] v,
                                                 input logic [LIVES_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + LIVES_W'(1);
  endfunction

endpackage

// File: rtl/lives_controller_frame_timer.sv
// Frame-paced 8-bit counter: advances on startOfFrame while enabled, clears
// synchronously, and flags the tick on which the count sits at limit_i.
module frame_timer
  import lives_controller_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic             tick_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_next_o,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && tick_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  assign done_o       = enable_i && tick_i && (count_q == limit_i);
  assign count_next_o = count_d;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lives_controller.sv
// Player life bookkeeping and round sequencing: ready period, play, death
// animation with respawn, and game over. All outputs come straight from flops.
module lives_controller
  import lives_controller_pkg::*;
#(
  parameter int INIT_LIVES   = DEF_INIT_LIVES,
  parameter int MAX_LIVES    = DEF_MAX_LIVES,
  parameter int READY_FRAMES = DEF_READY_FRAMES,
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               game_start,
  input  logic               pacman_hit,
  input  logic               bonus_life,
  output logic [LIVES_W-1:0] lives,
  output logic               freeze,
  output logic               death_anim,
  output logic               respawn,
  output logic               game_over,
  output logic               lives_blink
);

  localparam logic [LIVES_W-1:0] INIT_L     = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0] MAX_L      = LIVES_W'(MAX_LIVES);
  localparam logic [CNT_W-1:0]   READY_LAST = CNT_W'(READY_FRAMES - 1);
  localparam logic [CNT_W-1:0]   DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               respawn_d;
  logic               freeze_q, death_anim_q, respawn_q, game_over_q, lives_blink_q;
  logic               timer_en, timer_clr, timer_done;
  logic [CNT_W-1:0]   timer_limit, count_next;

  assign timer_en    = (state_q == READY) || (state_q == DYING);
  assign timer_limit = (state_q == DYING) ? DEATH_LAST : READY_LAST;
  assign timer_clr   = (state_d != state_q);

  frame_timer u_frame_timer (
    .clk         (clk),
    .resetN      (resetN),
    .tick_i      (startOfFrame),
    .enable_i    (timer_en),
    .clear_i     (timer_clr),
    .limit_i     (timer_limit),
    .count_next_o(count_next),
    .done_o      (timer_done)
  );

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    respawn_d = 1'b0;
    unique case (state_q)
      IDLE, GAME_OVER: begin
        if (game_start) begin
          state_d = READY;
          lives_d = INIT_L;
        end
      end
      READY: begin
        if (bonus_life) lives_d = sat_inc(lives_q, MAX_L);
        if (timer_done) state_d = PLAY;
      end
      PLAY: begin
        if (pacman_hit) begin
          state_d = DYING;
          // A simultaneous bonus cancels the loss; clamp keeps lives from wrapping.
          if (!bonus_life) lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
        end else if (bonus_life) begin
          lives_d = sat_inc(lives_q, MAX_L);
        end
      end
      DYING: begin
        if (bonus_life) lives_d = sat_inc(lives_q, MAX_L);
        if (timer_done) begin
          if (lives_q == '0) begin
            state_d = GAME_OVER;
          end else begin
            state_d   = READY;
            respawn_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      lives_q       <= INIT_L;
      freeze_q      <= 1'b1;
      death_anim_q  <= 1'b0;
      respawn_q     <= 1'b0;
      game_over_q   <= 1'b0;
      lives_blink_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      freeze_q      <= (state_d != PLAY);
      death_anim_q  <= (state_d == DYING);
      respawn_q     <= respawn_d;
      game_over_q   <= (state_d == GAME_OVER);
      lives_blink_q <= (state_d == DYING) && count_next[3];
    end
  end

  assign lives       = lives_q;
  assign freeze      = freeze_q;
  assign death_anim  = death_anim_q;
  assign respawn     = respawn_q;
  assign game_over   = game_over_q;
  assign lives_blink = lives_blink_q;

endmodule
